power_control: RTL and testbench

Charge-meter controller feeding the power-bar overlay and the projectile launcher. While the active player holds the fire button, it sweeps a 5-bit power value up and down (ping-pong) at a programmable rate. On release it emits a one-cycle throw strobe carrying the latched power and player. It sits upstream of `draw_power`, which consumes `power` and `current_player`.

---
 rtl/variable_pkg.sv | 16 +
 rtl/tick_divider.sv | 28 ++
 rtl/power_control.sv | 101 ++++++++++
 tb/tb_power_control.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/variable_pkg.sv
// Shared game constants: player encodings, meter limits and the charge-meter state type.
package variable_pkg;

  localparam logic [1:0] PLAYER_1 = 2'd1;
  localparam logic [1:0] PLAYER_2 = 2'd2;

  localparam logic [4:0] POWER_MAX = 5'd31;
  localparam logic [4:0] POWER_MIN = 5'd1;

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    FIRED
  } power_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running cycle divider: tick is high for one cycle every DIV cycles while clear is low.
module tick_divider #(
  parameter int DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = ~clear & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/power_control.sv
// Charge meter: ping-pongs power 1..31 while fire is held, emits a one-cycle throw on release.
module power_control
  import variable_pkg::*;
#(
  parameter int STEP_DIV = 1_000_000
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic [1:0] current_player,
  input  logic       fire,
  output logic [4:0] power,
  output logic       throw,
  output logic [4:0] throw_power,
  output logic [1:0] throw_player
);

  power_state_t state;
  logic         fire_q;
  logic [1:0]   player_q;
  logic         dir_up;
  logic         step_tick;
  logic         rise;
  logic         valid;
  logic         turn_change;
  logic [5:0]   next_step;

  // Next {direction, power} of the ping-pong sweep; bounces at both ends, never wraps.
  function automatic logic [5:0] sweep(input logic [4:0] p, input logic up);
    if (up) begin
      return (p >= POWER_MAX) ? {1'b0, POWER_MAX - 5'd1} : {1'b1, p + 5'd1};
    end else begin
      return (p <= POWER_MIN) ? {1'b1, POWER_MIN + 5'd1} : {1'b0, p - 5'd1};
    end
  endfunction

  assign rise        = fire & ~fire_q;
  assign valid       = (current_player == PLAYER_1) || (current_player == PLAYER_2);
  assign turn_change = (current_player != player_q);
  assign next_step   = sweep(power, dir_up);

  tick_divider #(
    .DIV(STEP_DIV)
  ) u_tick_divider (
    .clk  (clk60MHz),
    .rst  (rst),
    .clear(state != CHARGE),
    .tick (step_tick)
  );

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      power        <= '0;
      throw        <= 1'b0;
      throw_power  <= '0;
      throw_player <= '0;
      dir_up       <= 1'b1;
      fire_q       <= 1'b0;
      player_q     <= '0;
    end else begin
      fire_q   <= fire;
      player_q <= current_player;
      throw    <= 1'b0;
      // An aborted turn always wins, even over a same-cycle release.
      if (turn_change || !valid) begin
        state <= IDLE;
        power <= '0;
      end else begin
        case (state)
          IDLE: begin
            power <= '0;
            if (rise) begin
              state  <= CHARGE;
              power  <= POWER_MIN;
              dir_up <= 1'b1;
            end
          end
          CHARGE: begin
            if (!fire) begin
              state        <= FIRED;
              throw        <= 1'b1;
              throw_power  <= power;
              throw_player <= current_player;
            end else if (step_tick) begin
              dir_up <= next_step[5];
              power  <= next_step[4:0];
            end
          end
          FIRED: begin
            state <= FIRED;
          end
          default: begin
            state <= IDLE;
            power <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_power_control.sv
// Directed bench for power_control with STEP_DIV=4 and hand-computed meter values.
module tb_power_control;
  import variable_pkg::*;

  logic       clk60MHz;
  logic       rst;
  logic [1:0] current_player;
  logic       fire;
  logic [4:0] power;
  logic       throw;
  logic [4:0] throw_power;
  logic [1:0] throw_player;

  int checks = 0;
  int errors = 0;
  int throw_cnt = 0;

  power_control #(
    .STEP_DIV(4)
  ) dut (
    .clk60MHz      (clk60MHz),
    .rst           (rst),
    .current_player(current_player),
    .fire          (fire),
    .power         (power),
    .throw         (throw),
    .throw_power   (throw_power),
    .throw_player  (throw_player)
  );

  initial clk60MHz = 1'b0;
  always #5 clk60MHz = ~clk60MHz;

  always @(negedge clk60MHz) if (throw) throw_cnt++;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk60MHz);
    #1;
  endtask

  // Ping-pong model: k cycles after entering CHARGE with a step every 4 cycles.
  function automatic int sweep_val(input int k);
    int m;
    m = (k / 4) % 60;
    return (m <= 30) ? 1 + m : 61 - m;
  endfunction

  initial begin
    int pmax;
    int pmin;
    rst = 1'b1;
    fire = 1'b0;
    current_player = PLAYER_1;
    repeat (3) cycle();
    check_eq("reset_power", power, 0);
    check_eq("reset_throw", throw, 0);
    check_eq("reset_throw_power", throw_power, 0);
    check_eq("reset_throw_player", throw_player, 0);
    rst = 1'b0;

    repeat (5) cycle();
    check_eq("idle_power", power, 0);
    check_eq("idle_no_throw", throw_cnt, 0);

    // Charge to 9 and release
    fire = 1'b1;
    cycle();
    check_eq("charge_start", power, 1);
    check_eq("charge_start_throw", throw, 0);
    for (int k = 1; k <= 32; k++) begin
      cycle();
      check_eq($sformatf("ramp_k%0d", k), power, 1 + k / 4);
    end
    fire = 1'b0;
    cycle();
    check_eq("rel_throw", throw, 1);
    check_eq("rel_throw_power", throw_power, 9);
    check_eq("rel_throw_player", throw_player, PLAYER_1);
    check_eq("rel_power_hold", power, 9);
    cycle();
    check_eq("rel_throw_drop", throw, 0);
    check_eq("rel_power_hold2", power, 9);
    check_eq("rel_throw_power_hold", throw_power, 9);
    check_eq("throw_count_1", throw_cnt, 1);

    // Second press in the same turn
    fire = 1'b1;
    repeat (10) cycle();
    check_eq("repress_power", power, 9);
    fire = 1'b0;
    repeat (3) cycle();
    check_eq("repress_power2", power, 9);
    check_eq("repress_no_throw", throw_cnt, 1);

    // New turn: full sweep under PLAYER_2
    current_player = PLAYER_2;
    cycle();
    check_eq("turn_power_clear", power, 0);
    fire = 1'b1;
    cycle();
    check_eq("p2_start", power, 1);
    pmax = 1;
    pmin = 1;
    for (int k = 1; k <= 251; k++) begin
      cycle();
      check_eq($sformatf("sweep_k%0d", k), power, sweep_val(k));
      if (power > pmax) pmax = power;
      if (power < pmin) pmin = power;
    end
    check_eq("sweep_max", pmax, 31);
    check_eq("sweep_min", pmin, 1);
    // Release coincides with a step tick: the throw keeps the pre-step value
    fire = 1'b0;
    cycle();
    check_eq("tie_throw", throw, 1);
    check_eq("tie_throw_power", throw_power, 3);
    check_eq("tie_throw_player", throw_player, PLAYER_2);
    check_eq("tie_power", power, 3);
    cycle();
    check_eq("tie_power_hold", power, 3);
    check_eq("throw_count_2", throw_cnt, 2);

    // Abort mid-charge by a turn change with fire still held
    current_player = PLAYER_1;
    cycle();
    fire = 1'b1;
    cycle();
    check_eq("abort_start", power, 1);
    repeat (6) cycle();
    check_eq("abort_pre", power, 2);
    current_player = PLAYER_2;
    cycle();
    check_eq("abort_power", power, 0);
    check_eq("abort_throw", throw, 0);
    repeat (10) cycle();
    check_eq("held_no_charge", power, 0);
    check_eq("abort_no_throw", throw_cnt, 2);
    current_player = 2'd0;
    cycle();
    check_eq("invalid_power", power, 0);
    current_player = PLAYER_2;
    fire = 1'b0;
    repeat (2) cycle();
    fire = 1'b1;
    cycle();
    check_eq("new_rise_start", power, 1);
    repeat (5) cycle();
    check_eq("new_rise_step", power, 2);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_power", power, 0);
    check_eq("async_throw", throw, 0);
    check_eq("async_throw_power", throw_power, 0);
    check_eq("async_throw_player", throw_player, 0);
    #2;
    rst = 1'b0;
    repeat (3) cycle();
    check_eq("post_reset_idle", power, 0);
    fire = 1'b0;
    repeat (2) cycle();
    check_eq("final_throw_count", throw_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
